// File: rtl/uart_pkg.sv
// Shared types, default constants and increment math for the UART baud generator.
package uart_pkg;

  typedef enum logic [1:0] {
    B9600  = 2'd0,
    B19200 = 2'd1,
    B38400 = 2'd2,
    B57600 = 2'd3
  } baud_sel_t;

  localparam int unsigned UART_CLK_HZ_DEF = 1000000;
  localparam int unsigned UART_OS_DEF     = 8;

  // round(baud*os*2^acc_w / clk_hz), done in 64-bit integer arithmetic
  function automatic longint unsigned calc_inc(
    input longint unsigned clk_hz,
    input longint unsigned baud,
    input longint unsigned os,
    input int unsigned     acc_w
  );
    return (((baud * os) << acc_w) + (clk_hz / 2)) / clk_hz;
  endfunction

endpackage

// File: rtl/uart_os_counter.sv
// Oversample phase counter: counts steps modulo OVERSAMPLE and strobes on wrap.
module uart_os_counter #(
  parameter int unsigned OVERSAMPLE = 8
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       clr_i,
  input  logic       step_i,
  output logic [3:0] phase_o,
  output logic       wrap_o
);

  logic [3:0] r_phase;
  logic       r_wrap;
  logic       w_last;

  assign w_last = (r_phase == 4'(OVERSAMPLE - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      r_phase <= 4'd0;
      r_wrap  <= 1'b0;
    end else if (step_i) begin
      r_phase <= w_last ? 4'd0 : r_phase + 4'd1;
      r_wrap  <= w_last;
    end else begin
      r_wrap  <= 1'b0;
    end
  end

  assign phase_o = r_phase;
  assign wrap_o  = r_wrap;

endmodule

// File: rtl/uart_baud_gen.sv
// NCO baud tick generator with four selectable rates and programmable oversampling.
// Optional toggled baud clock outputs are enabled by defining UART_BAUD_CLK_OUT_EN.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ     = UART_CLK_HZ_DEF,
  parameter int unsigned OVERSAMPLE = UART_OS_DEF,
  parameter int unsigned ACC_W      = 24,
  parameter int unsigned BAUD0      = 9600,
  parameter int unsigned BAUD1      = 19200,
  parameter int unsigned BAUD2      = 38400,
  parameter int unsigned BAUD3      = 57600
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       en_i,
  input  logic [1:0] baud_sel_i,
  input  logic       tx_sync_i,
  output logic       rx_tick_o,
  output logic       tx_tick_o,
  output logic [3:0] bit_phase_o
`ifdef UART_BAUD_CLK_OUT_EN
  ,
  output logic       rx_clk_o,
  output logic       tx_clk_o
`endif
);

  localparam int unsigned BAUD_TAB [4] = '{BAUD0, BAUD1, BAUD2, BAUD3};
  localparam longint unsigned INC_TAB [4] = '{
    calc_inc(64'(CLK_HZ), 64'(BAUD0), 64'(OVERSAMPLE), ACC_W),
    calc_inc(64'(CLK_HZ), 64'(BAUD1), 64'(OVERSAMPLE), ACC_W),
    calc_inc(64'(CLK_HZ), 64'(BAUD2), 64'(OVERSAMPLE), ACC_W),
    calc_inc(64'(CLK_HZ), 64'(BAUD3), 64'(OVERSAMPLE), ACC_W)
  };

  if (OVERSAMPLE < 2 || OVERSAMPLE > 16) begin : g_bad_os
    $error("uart_baud_gen: OVERSAMPLE must be 2..16");
  end

  logic [ACC_W-1:0] w_inc_tab [4];

  genvar gi;
  for (gi = 0; gi < 4; gi++) begin : g_inc
    if ((64'(BAUD_TAB[gi]) * 64'(OVERSAMPLE) >= 64'(CLK_HZ)) || (INC_TAB[gi] == 64'd0)) begin : g_bad_rate
      $error("uart_baud_gen: baud rate %0d unreachable at this clock", gi);
    end
    assign w_inc_tab[gi] = ACC_W'(INC_TAB[gi]);
  end

  logic [ACC_W-1:0] r_acc;
  logic             r_rx_tick;
  baud_sel_t        r_sel;
  logic [ACC_W:0]   w_sum;
  logic             w_clr;
  logic             w_step;

  assign w_sum  = {1'b0, r_acc} + {1'b0, w_inc_tab[r_sel]};
  // A rate change restarts from a clean phase, same as an explicit realign.
  assign w_clr  = tx_sync_i | (baud_sel_i != 2'(r_sel));
  assign w_step = en_i & ~w_clr & w_sum[ACC_W];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_acc     <= '0;
      r_rx_tick <= 1'b0;
      r_sel     <= B9600;
    end else begin
      r_sel <= baud_sel_t'(baud_sel_i);
      if (w_clr) begin
        r_acc     <= '0;
        r_rx_tick <= 1'b0;
      end else if (en_i) begin
        r_acc     <= w_sum[ACC_W-1:0];
        r_rx_tick <= w_sum[ACC_W];
      end else begin
        r_rx_tick <= 1'b0;
      end
    end
  end

  uart_os_counter #(
    .OVERSAMPLE (OVERSAMPLE)
  ) u_os_counter (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clr_i   (w_clr),
    .step_i  (w_step),
    .phase_o (bit_phase_o),
    .wrap_o  (tx_tick_o)
  );

  assign rx_tick_o = r_rx_tick;

`ifdef UART_BAUD_CLK_OUT_EN
  logic r_rx_clk;
  logic r_tx_clk;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rx_clk <= 1'b0;
      r_tx_clk <= 1'b0;
    end else begin
      r_rx_clk <= r_rx_clk ^ r_rx_tick;
      r_tx_clk <= r_tx_clk ^ tx_tick_o;
    end
  end

  assign rx_clk_o = r_rx_clk;
  assign tx_clk_o = r_tx_clk;
`endif

endmodule

// File: tb/tb_uart_baud_gen.sv
// Self-checking bench for uart_baud_gen: rate table, corner sequences, randomized run vs model.
module tb_uart_baud_gen;

  localparam int unsigned OS    = 8;
  localparam int unsigned ACC_W = 24;
  localparam longint unsigned MOD = 64'd1 << ACC_W;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [1:0] sel;
  logic       sync;
  logic       rx_tick;
  logic       tx_tick;
  logic [3:0] bit_phase;
`ifdef UART_BAUD_CLK_OUT_EN
  logic       rx_clk;
  logic       tx_clk;
`endif

  uart_baud_gen dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .en_i        (en),
    .baud_sel_i  (sel),
    .tx_sync_i   (sync),
    .rx_tick_o   (rx_tick),
    .tx_tick_o   (tx_tick),
    .bit_phase_o (bit_phase)
`ifdef UART_BAUD_CLK_OUT_EN
    ,
    .rx_clk_o    (rx_clk),
    .tx_clk_o    (tx_clk)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Behavioural reference state
  longint unsigned inc_ref [4];
  longint unsigned m_acc = 0;
  int              m_phase = 0;
  logic [1:0]      m_selq = 2'd0;
  bit              m_rx = 0, m_tx = 0, m_rxclk = 0, m_txclk = 0;

  function automatic longint unsigned ref_inc(input int baud);
    real x;
    x = real'(baud) * real'(OS) * (2.0 ** ACC_W) / 1.0e6;
    return longint'($rtoi(x + 0.5));
  endfunction

  task automatic model_step();
    bit prx, ptx;
    longint unsigned s;
    prx = m_rx;
    ptx = m_tx;
    if (rst) begin
      m_acc = 0; m_phase = 0; m_rx = 0; m_tx = 0; m_selq = 2'd0;
      m_rxclk = 0; m_txclk = 0;
    end else begin
      m_rxclk ^= prx;
      m_txclk ^= ptx;
      if (sync || sel != m_selq) begin
        m_acc = 0; m_phase = 0; m_rx = 0; m_tx = 0;
      end else if (en) begin
        s = m_acc + inc_ref[m_selq];
        m_rx = (s >= MOD);
        m_acc = s % MOD;
        m_tx = 0;
        if (m_rx) begin
          m_phase = (m_phase + 1) % OS;
          m_tx = (m_phase == 0);
        end
      end else begin
        m_rx = 0; m_tx = 0;
      end
      m_selq = sel;
    end
  endtask

  task automatic check_outputs(input string tag);
    logic [7:0] act, exp;
    act = {2'b00, rx_tick, tx_tick, bit_phase};
    exp = {2'b00, m_rx, m_tx, 4'(m_phase)};
`ifdef UART_BAUD_CLK_OUT_EN
    act[7:6] = {rx_clk, tx_clk};
    exp[7:6] = {m_rxclk, m_txclk};
`endif
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got clks=%b rx=%b tx=%b phase=%0d, want clks=%b rx=%b tx=%b phase=%0d",
               tag, act[7:6], act[5], act[4], act[3:0], exp[7:6], exp[5], exp[4], exp[3:0]);
    end
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_step();
    #1;
    check_outputs(tag);
  endtask

  task automatic chk(input string name, input longint act, input longint lo, input longint hi);
    n_vec++;
    if (act < lo || act > hi) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic do_reset(input logic [1:0] s);
    rst = 1; sel = s; en = 1; sync = 0;
    tick("reset");
    chk("reset_state", longint'({rx_tick, tx_tick, bit_phase}), 0, 0);
    rst = 0;
  endtask

  typedef struct {
    logic [1:0] sel;
    int ncyc;
    int rx_lo, rx_hi, tx_lo, tx_hi, gap_lo, gap_hi;
  } rate_vec_t;

  rate_vec_t tbl [4];

  initial begin
    int rxc, txc, last, gmin, gmax, c0, c1, found;
    for (int k = 0; k < 4; k++) inc_ref[k] = 0;
    inc_ref[0] = ref_inc(9600);
    inc_ref[1] = ref_inc(19200);
    inc_ref[2] = ref_inc(38400);
    inc_ref[3] = ref_inc(57600);

    tbl[0] = '{2'd0, 10000,  767,  768,  95,  96, 13, 14};
    tbl[1] = '{2'd1, 10000, 1535, 1536, 191, 192,  6,  7};
    tbl[2] = '{2'd2, 10000, 3071, 3072, 383, 384,  3,  4};
    tbl[3] = '{2'd3, 10000, 4607, 4608, 575, 576,  2,  3};

    rst = 1; en = 0; sel = 2'd0; sync = 0;
    tick("power_on");
    chk("sel3_inc", longint'(inc_ref[3]), 7730941, 7730941);

    // Rate table: counts and tick spacing per baud select
    for (int v = 0; v < 4; v++) begin
      do_reset(tbl[v].sel);
      rxc = 0; txc = 0; last = -1; gmin = 1 << 30; gmax = 0;
      for (int c = 0; c < tbl[v].ncyc; c++) begin
        tick("rate_run");
        if (rx_tick) begin
          if (last >= 0) begin
            if (c - last < gmin) gmin = c - last;
            if (c - last > gmax) gmax = c - last;
          end
          last = c;
          rxc++;
        end
        if (tx_tick) txc++;
      end
      chk("rate_rx_count", rxc, tbl[v].rx_lo, tbl[v].rx_hi);
      chk("rate_tx_count", txc, tbl[v].tx_lo, tbl[v].tx_hi);
      chk("rate_gap_min", gmin, tbl[v].gap_lo, tbl[v].gap_hi);
      chk("rate_gap_max", gmax, tbl[v].gap_lo, tbl[v].gap_hi);
      $display("vec %0d sel=%0d rx=%0d tx=%0d gap=%0d..%0d", v, tbl[v].sel, rxc, txc, gmin, gmax);
    end

    // Rate switch 0 -> 1 mid-run
    do_reset(2'd0);
    c0 = 0;
    for (int c = 0; c < 2000; c++) begin tick("sw_sel0"); c0 += int'(rx_tick); end
    sel = 2'd1;
    tick("sw_edge");
    chk("sw_clear", longint'({rx_tick, tx_tick, bit_phase}), 0, 0);
    c1 = 0;
    for (int c = 0; c < 2000; c++) begin tick("sw_sel1"); c1 += int'(rx_tick); end
    chk("sw_count0", c0, 153, 154);
    chk("sw_double", c1, 2 * c0 - 2, 2 * c0 + 2);
    $display("seq sel_switch c0=%0d c1=%0d", c0, c1);

    // Enable gap with phase 5
    do_reset(2'd0);
    for (int c = 0; c < 2000 && m_phase != 5; c++) tick("gap_seek");
    chk("gap_phase5", bit_phase, 5, 5);
    en = 0;
    rxc = 0;
    for (int c = 0; c < 50; c++) begin
      tick("gap_hold");
      rxc += int'(rx_tick) + int'(tx_tick);
    end
    chk("gap_no_ticks", rxc, 0, 0);
    chk("gap_hold5", bit_phase, 5, 5);
    en = 1;
    found = 0;
    for (int c = 0; c < 100 && found == 0; c++) begin
      tick("gap_resume");
      if (rx_tick) found = 1;
    end
    chk("gap_resume_tick", found, 1, 1);
    chk("gap_resume6", bit_phase, 6, 6);
    $display("seq en_gap resume_phase=%0d", bit_phase);

    // Sync coinciding with a would-be tx tick
    do_reset(2'd0);
    found = 0;
    for (int c = 0; c < 3000 && found == 0; c++) begin
      tick("sync_seek");
      if (m_phase == OS - 1 && m_acc + inc_ref[0] >= MOD) found = 1;
    end
    chk("sync_found", found, 1, 1);
    sync = 1;
    tick("sync_edge");
    sync = 0;
    chk("sync_clear", longint'({rx_tick, tx_tick, bit_phase}), 0, 0);
    rxc = 0; found = 0;
    for (int c = 0; c < 500 && found == 0; c++) begin
      tick("sync_bit");
      rxc += int'(rx_tick);
      if (tx_tick) found = 1;
    end
    chk("sync_tx_seen", found, 1, 1);
    chk("sync_rx_per_bit", rxc, OS, OS);
    $display("seq sync rx_before_tx=%0d", rxc);

    // Reset mid-bit
    do_reset(2'd2);
    for (int c = 0; c < 500 && m_phase != 3; c++) tick("rst_seek");
    rst = 1;
    tick("rst_mid");
    rst = 0;
    chk("rst_mid_out", longint'({rx_tick, tx_tick, bit_phase}), 0, 0);
`ifdef UART_BAUD_CLK_OUT_EN
    chk("rst_mid_clks", longint'({rx_clk, tx_clk}), 0, 0);
`endif
    $display("seq reset_mid phase=%0d", bit_phase);

    // Randomized run against the model
    do_reset(2'($urandom_range(0, 3)));
    for (int c = 0; c < 4000; c++) begin
      rst  = ($urandom_range(0, 999) < 3);
      en   = ($urandom_range(0, 99) < 90);
      sync = ($urandom_range(0, 99) < 1);
      if ($urandom_range(0, 99) < 1) sel = 2'($urandom_range(0, 3));
      tick("random");
    end
    $display("seq random done");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
